// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: memory req/gnt/rvalid, redirect and decode-side signals of the fetch front-end.
interface fetch_prefetch_queue_if #(
   parameter int DEPTH = 4
);
   logic                     flush;
   logic [31:0]              flush_target;
   logic                     imem_req;
   logic [31:0]              imem_addr;
   logic                     imem_gnt;
   logic                     imem_rvalid;
   logic [31:0]              imem_rdata;
   logic                     instr_valid;
   logic                     instr_ready;
   logic [31:0]              instr;
   logic [31:0]              pc;
   logic                     misaligned;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      input  flush, flush_target, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr, pc, misaligned, level
   );

   modport slave (
      output flush, flush_target, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr, pc, misaligned, level
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: credit-limited prefetch FIFO between imem and decode with redirect flush.
// Define FETCH_PREFETCH_PERF_EN to add saturating stall_cnt/discard_cnt counters.
module fetch_prefetch_queue #(
   parameter logic [31:0] START_ADDRESS   = 32'h0,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sys_reset,
`ifdef FETCH_PREFETCH_PERF_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] discard_cnt,
`endif
   fetch_prefetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [31:0]   data_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];
   logic          mis_q [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level, outstanding, discard, outstanding_nx;
   logic [31:0]   addr, resp_pc, hold_target, target;
   logic          run, hold, mis_next;
   logic          req, fire, drop, push, pop, valid;

   assign target         = {bus.flush_target[31:2], 2'b00};
   assign valid          = level != '0;
   assign req            = run && !sys_reset && outstanding < LW'(MAX_OUTSTANDING) &&
                           ({1'b0, level} + {1'b0, outstanding}) < (LW+1)'(DEPTH);
   assign fire           = req && bus.imem_gnt;
   assign drop           = bus.imem_rvalid && (discard != '0 || bus.flush);
   assign push           = bus.imem_rvalid && discard == '0 && !bus.flush;
   assign pop            = valid && bus.instr_ready && !bus.flush;
   assign outstanding_nx = outstanding + LW'(fire) - LW'(bus.imem_rvalid);

   // every in-flight request at a redirect or soft reset becomes a response to drop
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         outstanding <= '0;
         discard     <= '0;
         addr        <= START_ADDRESS;
         resp_pc     <= START_ADDRESS;
         hold_target <= START_ADDRESS;
         run         <= 1'b0;
         hold        <= 1'b0;
         mis_next    <= 1'b0;
      end else if (sys_reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         outstanding <= outstanding_nx;
         discard     <= outstanding_nx;
         addr        <= START_ADDRESS;
         resp_pc     <= START_ADDRESS;
         hold_target <= START_ADDRESS;
         run         <= 1'b0;
         hold        <= 1'b0;
         mis_next    <= 1'b0;
      end else begin
         run         <= 1'b1;
         outstanding <= outstanding_nx;
         if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            discard     <= outstanding_nx;
            resp_pc     <= target;
            hold_target <= target;
            mis_next    <= bus.flush_target[1];
            hold        <= req && !bus.imem_gnt;
            if (!(req && !bus.imem_gnt))
               addr <= target;
         end else begin
            // a held pre-redirect request is dropped once it is finally granted
            discard <= discard - LW'(drop) + LW'(hold && fire);
            if (fire) begin
               hold <= 1'b0;
               addr <= hold ? hold_target : addr + 32'd4;
            end
            if (push) begin
               wr_ptr   <= wr_ptr + 1'b1;
               resp_pc  <= resp_pc + 32'd4;
               mis_next <= 1'b0;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
         end
      end

   always_ff @(posedge clk)
      if (push) begin
         data_q[wr_ptr] <= bus.imem_rdata;
         pc_q[wr_ptr]   <= resp_pc;
         mis_q[wr_ptr]  <= mis_next;
      end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = addr;
   assign bus.instr_valid = valid;
   assign bus.instr       = valid ? data_q[rd_ptr] : 32'h0000_0013;
   assign bus.pc          = valid ? pc_q[rd_ptr] : 32'h0;
   assign bus.misaligned  = valid && mis_q[rd_ptr];
   assign bus.level       = level;

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && level == LW'(DEPTH)));

`ifdef FETCH_PREFETCH_PERF_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         stall_cnt   <= '0;
         discard_cnt <= '0;
      end else if (sys_reset) begin
         stall_cnt   <= '0;
         discard_cnt <= '0;
      end else begin
         if (bus.instr_ready && !valid && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (drop && discard_cnt != '1)
            discard_cnt <= discard_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: vector table, directed redirect/wrap/soft-reset sequences, random traffic vs. stream model.
module tb_fetch_prefetch_queue;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sys_reset = 1'b0;
   int   total = 0;
   int   bad = 0;
`ifdef FETCH_PREFETCH_PERF_EN
   logic [31:0] stall_cnt, discard_cnt;
`endif

   fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_prefetch_queue #(.START_ADDRESS(32'h0), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sys_reset   (sys_reset),
`ifdef FETCH_PREFETCH_PERF_EN
      .stall_cnt   (stall_cnt),
      .discard_cnt (discard_cnt),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", name, got, want, $time);
      end
   endtask

   task automatic cyc(input logic g, input logic rv, input logic [31:0] ra, input logic rdy,
                      input logic fl, input logic [31:0] tgt, input logic sr);
      @(negedge clk);
      bus.imem_gnt     = g;
      bus.imem_rvalid  = rv;
      bus.imem_rdata   = rv ? mem_word(ra) : 32'h0;
      bus.instr_ready  = rdy;
      bus.flush        = fl;
      bus.flush_target = tgt;
      sys_reset        = sr;
      #1;
   endtask

   task automatic sysrst();
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("sysrst_req", 32'(bus.imem_req), 0);
   endtask

   task automatic chk_head(input string name, input logic [31:0] pc, input logic mis);
      chk({name, "_valid"}, 32'(bus.instr_valid), 1);
      chk({name, "_pc"}, bus.pc, pc);
      chk({name, "_instr"}, bus.instr, mem_word(pc));
      chk({name, "_mis"}, 32'(bus.misaligned), 32'(mis));
   endtask

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] ra;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      int          lvl;
   } vec_t;

   vec_t        tbl [14];
   logic [31:0] memq [$];
   logic [31:0] exp_pc, pend_addr, tgt, rdat;
   logic        exp_mis, pend, sr, fl, g, rv, rdy;
   int          pops;

   initial begin
      tbl[0]  = '{0, 0, 32'h00, 0, 0, 32'h00, 0, 32'h0, 0};
      tbl[1]  = '{1, 0, 32'h00, 0, 1, 32'h00, 0, 32'h0, 0};
      tbl[2]  = '{1, 1, 32'h00, 0, 1, 32'h04, 0, 32'h0, 0};
      tbl[3]  = '{1, 1, 32'h04, 0, 1, 32'h08, 1, 32'h0, 1};
      tbl[4]  = '{1, 1, 32'h08, 0, 1, 32'h0C, 1, 32'h0, 2};
      tbl[5]  = '{1, 1, 32'h0C, 0, 0, 32'h10, 1, 32'h0, 3};
      tbl[6]  = '{1, 0, 32'h00, 0, 0, 32'h10, 1, 32'h0, 4};
      tbl[7]  = '{1, 0, 32'h00, 1, 0, 32'h10, 1, 32'h0, 4};
      tbl[8]  = '{1, 0, 32'h00, 1, 1, 32'h10, 1, 32'h4, 3};
      tbl[9]  = '{1, 1, 32'h10, 1, 1, 32'h14, 1, 32'h8, 2};
      tbl[10] = '{0, 1, 32'h14, 1, 1, 32'h18, 1, 32'hC, 2};
      tbl[11] = '{0, 0, 32'h00, 1, 1, 32'h18, 1, 32'h10, 2};
      tbl[12] = '{0, 0, 32'h00, 1, 1, 32'h18, 1, 32'h14, 1};
      tbl[13] = '{0, 0, 32'h00, 1, 1, 32'h18, 0, 32'h0, 0};

      bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
      bus.instr_ready = 0; bus.flush = 0; bus.flush_target = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req), 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_instr", bus.instr, 32'h13);
      chk("rst_pc", bus.pc, 0);
      chk("rst_mis", 32'(bus.misaligned), 0);
      reset_n = 1'b1;

      // fill with ready low, then drain: credit stops at 4 entries
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].gnt, tbl[i].rv, tbl[i].ra, tbl[i].rdy, 0, 0, 0);
         chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
         chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].addr);
         chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
         chk($sformatf("v%0d_pc", i), bus.pc, tbl[i].pc);
         chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
         chk($sformatf("v%0d_instr", i), bus.instr, tbl[i].valid ? mem_word(tbl[i].pc) : 32'h13);
      end

      // two in flight, redirect to 0x100
      sysrst();
      cyc(0, 0, 0, 0, 0, 0, 0);          chk("a0_req", 32'(bus.imem_req), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("a1_addr", bus.imem_addr, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("a2_addr", bus.imem_addr, 4);
      cyc(0, 0, 0, 0, 1, 32'h100, 0);    chk("a3_req", 32'(bus.imem_req), 0);
      cyc(0, 1, 32'h0, 0, 0, 0, 0);      chk("a4_req", 32'(bus.imem_req), 0);
      cyc(0, 1, 32'h4, 0, 0, 0, 0);      chk("a5_addr", bus.imem_addr, 32'h100);
      chk("a5_valid", 32'(bus.instr_valid), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("a6_valid", 32'(bus.instr_valid), 0);
      chk("a6_req", 32'(bus.imem_req), 1);
      cyc(0, 1, 32'h100, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);          chk_head("a8", 32'h100, 0);

      // redirect while a request is stalled on gnt
      sysrst();
      cyc(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         chk("b_stall_req", 32'(bus.imem_req), 1);
         chk("b_stall_addr", bus.imem_addr, 0);
      end
      cyc(0, 0, 0, 0, 1, 32'h200, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);          chk("b_hold_addr", bus.imem_addr, 0);
      chk("b_hold_req", 32'(bus.imem_req), 1);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("b_gnt_addr", bus.imem_addr, 0);
      cyc(0, 1, 32'h0, 0, 0, 0, 0);      chk("b_tgt_addr", bus.imem_addr, 32'h200);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("b_drop_valid", 32'(bus.instr_valid), 0);
      cyc(0, 1, 32'h200, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);          chk_head("b_head", 32'h200, 0);

      // misaligned target tags only the first entry
      sysrst();
      cyc(0, 0, 0, 0, 1, 32'h302, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("c1_addr", bus.imem_addr, 32'h300);
      cyc(1, 1, 32'h300, 0, 0, 0, 0);    chk("c2_addr", bus.imem_addr, 32'h304);
      cyc(0, 1, 32'h304, 1, 0, 0, 0);    chk_head("c3", 32'h300, 1);
      cyc(0, 0, 0, 1, 0, 0, 0);          chk_head("c4", 32'h304, 0);

      // address wrap, then soft reset with a response still in flight
      sysrst();
      cyc(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("d1_addr", bus.imem_addr, 32'hFFFF_FFF8);
      cyc(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0); chk("d2_addr", bus.imem_addr, 32'hFFFF_FFFC);
      cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); chk("d3_wrap", bus.imem_addr, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);          chk_head("d4", 32'hFFFF_FFF8, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);          chk_head("d5", 32'hFFFF_FFFC, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("d6_addr", bus.imem_addr, 0);
      sysrst();
      cyc(0, 1, 32'h0, 0, 0, 0, 0);
      chk("d8_req", 32'(bus.imem_req), 0);
      chk("d8_addr", bus.imem_addr, 0);
      chk("d8_level", 32'(bus.level), 0);
      chk("d8_instr", bus.instr, 32'h13);
      cyc(1, 0, 0, 0, 0, 0, 0);          chk("d9_valid", 32'(bus.instr_valid), 0);
      chk("d9_req", 32'(bus.imem_req), 1);
      cyc(0, 1, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);          chk_head("d11", 32'h0, 0);
      chk("d11_level", 32'(bus.level), 1);

      // random traffic: decode must see target, target+4, ... after each redirect
      sysrst();
      exp_pc = 0; exp_mis = 0; pend = 0; pend_addr = 0; pops = 0;
      for (int i = 0; i < 4000; i++) begin
         sr  = ($urandom % 300) == 0;
         fl  = !sr && ($urandom % 40) == 0;
         tgt = $urandom;
         g   = ($urandom % 4) != 0;
         rv  = memq.size() != 0 && ($urandom % 3) != 0;
         rdat = rv ? memq[0] : 32'h0;
         rdy = ($urandom % 4) != 0;
         cyc(g, rv, rdat, rdy, fl, tgt, sr);
         if (pend && !sr) begin
            chk("r_hold_req", 32'(bus.imem_req), 1);
            chk("r_hold_addr", bus.imem_addr, pend_addr);
         end
         if (bus.imem_req)
            chk("r_inflight", 32'(memq.size() < MAXO), 1);
         if (!bus.instr_valid) begin
            chk("r_empty_instr", bus.instr, 32'h13);
            chk("r_empty_pc", bus.pc, 0);
         end
         if (sr) begin
            chk("r_sr_req", 32'(bus.imem_req), 0);
            exp_pc = 0;
            exp_mis = 0;
         end else if (fl) begin
            exp_pc = {tgt[31:2], 2'b00};
            exp_mis = tgt[1];
         end else if (bus.instr_valid && rdy) begin
            chk_head("r_pop", exp_pc, exp_mis);
            exp_pc += 4;
            exp_mis = 0;
            pops++;
         end
         pend = bus.imem_req && !g;
         pend_addr = bus.imem_addr;
         if (rv) void'(memq.pop_front());
         if (bus.imem_req && g) memq.push_back(bus.imem_addr);
      end
      chk("r_progress", 32'(pops > 500), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
